// File: rtl/chime_pkg.sv
// Shared state encoding and sizing helpers for the doorbell chime sequencer.
// The typed enum reuses the raw encodings so both views always agree.
package chime_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DING = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONG = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StDing = DING,
    StGap  = GAP,
    StDong = DONG
  } chime_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : int'($clog2(n));
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: output low for HALF cycles, high for HALF cycles, and so on,
// starting low on the first enabled cycle. Dropping en clears it completely.
module tone_div
  import chime_pkg::*;
#(
  parameter int unsigned HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tone
);

  localparam int unsigned CntW = cnt_width(HALF);
  localparam logic [CntW-1:0] Last = CntW'(HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tone_q, tone_d;
  logic            run_q, run_d;

  // en is the enable for the coming cycle; run_q marks that the first cycle has begun.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    run_d  = run_q;
    if (!en) begin
      cnt_d  = '0;
      tone_d = 1'b0;
      run_d  = 1'b0;
    end else if (!run_q) begin
      cnt_d  = '0;
      tone_d = 1'b0;
      run_d  = 1'b1;
    end else if (cnt_q == Last) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      run_q  <= run_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/chime_sequencer.sv
// Doorbell chime sequencer: a button press plays tone A (ding), an optional silent
// gap, then tone B (dong), and pulses done. All outputs come straight from flops.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int unsigned HALF_A   = 4,
  parameter int unsigned HALF_B   = 6,
  parameter int unsigned DING_CYC = 32,
  parameter int unsigned GAP_CYC  = 8,
  parameter int unsigned DONG_CYC = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic tone_a,
  output logic tone_b,
  output logic sel,
  output logic busy,
  output logic done
);

  localparam int unsigned MaxPhase = max3(DING_CYC, GAP_CYC, DONG_CYC);
  localparam int unsigned CntW     = cnt_width(MaxPhase);

  localparam logic [CntW-1:0] DingLast = CntW'(DING_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [CntW-1:0] DongLast = CntW'(DONG_CYC - 1);

  logic sync1_q, sync2_q, sync3_q;
  logic press;

  chime_state_e    state_q, state_d;
  logic [CntW-1:0] phase_q, phase_d;

  logic busy_q, sel_q, done_q;
  logic en_a, en_b;

  // Button synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign press = sync2_q & ~sync3_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (press) state_d = StDing;
      end
      StDing: begin
        if (phase_q == DingLast) state_d = (GAP_CYC == 0) ? StDong : StGap;
      end
      StGap: begin
        if (phase_q == GapLast) state_d = StDong;
      end
      StDong: begin
        // Presses here are dropped, including one coinciding with the return to idle.
        if (phase_q == DongLast) state_d = StIdle;
      end
    endcase
    if (state_d != state_q) phase_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      sel_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != StIdle);
      sel_q  <= (state_d == StDong);
      done_q <= (state_q == StDong) && (state_d == StIdle);
    end
  end

  assign en_a = (state_d == StDing);
  assign en_b = (state_d == StDong);

  tone_div #(
    .HALF(HALF_A)
  ) u_tone_a (
    .clk (clk),
    .rst (rst),
    .en  (en_a),
    .tone(tone_a)
  );

  tone_div #(
    .HALF(HALF_B)
  ) u_tone_b (
    .clk (clk),
    .rst (rst),
    .en  (en_b),
    .tone(tone_b)
  );

  assign busy = busy_q;
  assign sel  = sel_q;
  assign done = done_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Scoreboard bench for chime_sequencer: expected per-cycle outputs are queued when a
// press is driven and compared on each falling edge.
module tb_chime_sequencer;

  typedef struct packed {
    logic tone_a;
    logic tone_b;
    logic sel;
    logic busy;
    logic done;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic s_button = 1'b0;

  logic tone_a, tone_b, sel, busy, done;
  logic s_tone_a, s_tone_b, s_sel, s_busy, s_done;

  outs_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  chime_sequencer u_dut (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .tone_a(tone_a),
    .tone_b(tone_b),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  chime_sequencer #(
    .HALF_A  (4),
    .HALF_B  (6),
    .DING_CYC(1),
    .GAP_CYC (0),
    .DONG_CYC(1)
  ) u_small (
    .clk   (clk),
    .rst   (rst),
    .button(s_button),
    .tone_a(s_tone_a),
    .tone_b(s_tone_b),
    .sel   (s_sel),
    .busy  (s_busy),
    .done  (s_done)
  );

  function automatic outs_t actual(input int which);
    outs_t a;
    if (which == 0) a = {tone_a, tone_b, sel, busy, done};
    else a = {s_tone_a, s_tone_b, s_sel, s_busy, s_done};
    return a;
  endfunction

  task automatic push_idle(input int n);
    outs_t z;
    z = '0;
    repeat (n) exp_q.push_back(z);
  endtask

  // Expected trace from a press driven at a falling edge: two idle cycles of
  // synchroniser latency, the full sequence, the done cycle, then idle tail.
  task automatic push_seq(input int ding, input int gap, input int dong, input int ha,
                          input int hb, input int tail);
    outs_t e;
    push_idle(2);
    for (int i = 0; i < ding + gap + dong; i++) begin
      e = '0;
      e.busy = 1'b1;
      if (i < ding) begin
        e.tone_a = ((i / ha) % 2) == 1;
      end else if (i >= ding + gap) begin
        e.sel    = 1'b1;
        e.tone_b = (((i - ding - gap) / hb) % 2) == 1;
      end
      exp_q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
    push_idle(tail);
  endtask

  task automatic test_reset();
    outs_t a, e;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (actual(0) !== 5'b0) $display("FAIL reset_async: got %b want 00000", actual(0));
    else n_pass++;
    n_checks++;
    if (actual(1) !== 5'b0) $display("FAIL reset_async_small: got %b want 00000", actual(1));
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_idle(4);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL reset_idle[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
  endtask

  task automatic test_basic_sequence();
    outs_t a, e;
    button = 1'b1;
    fork
      begin
        repeat (10) @(negedge clk);
        button = 1'b0;
      end
    join_none
    push_seq(32, 8, 48, 4, 6, 4);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL basic[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_press();
    outs_t a, e;
    button = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk);
        button = 1'b0;
        repeat (19) @(negedge clk);
        button = 1'b1;
        repeat (5) @(negedge clk);
        button = 1'b0;
      end
    join_none
    push_seq(32, 8, 48, 4, 6, 6);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL ignore_press[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
  endtask

  task automatic test_held_no_retrigger();
    outs_t a, e;
    button = 1'b1;
    push_seq(32, 8, 48, 4, 6, 12);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL held_button[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
    button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_dong();
    outs_t a, e;
    button = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk);
        button = 1'b0;
      end
    join_none
    push_seq(32, 8, 48, 4, 6, 0);
    // Run up to DONG cycle 10 (trace index 50, queue entry 52).
    for (int idx = 0; idx < 53; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL pre_abort[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (actual(0) !== 5'b0) $display("FAIL abort_async: got %b want 00000", actual(0));
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_idle(6);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL abort_no_done[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
    button = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk);
        button = 1'b0;
      end
    join_none
    push_seq(32, 8, 48, 4, 6, 4);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL fresh_after_abort[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_button_held();
    outs_t a, e;
    button = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (actual(0) !== 5'b0) $display("FAIL held_in_reset: got %b want 00000", actual(0));
    else n_pass++;
    rst = 1'b0;
    push_seq(32, 8, 48, 4, 6, 4);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(0);
      n_checks++;
      if (a !== e) $display("FAIL start_after_reset[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
    button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_short_config();
    outs_t a, e;
    s_button = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk);
        s_button = 1'b0;
      end
    join_none
    push_seq(1, 0, 1, 4, 6, 3);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      a = actual(1);
      n_checks++;
      if (a !== e) $display("FAIL short_cfg[%0d]: got %b want %b", idx, a, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_ignore_press();
    test_held_no_retrigger();
    test_reset_mid_dong();
    test_reset_button_held();
    test_short_config();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
